// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Multi-cycle barrel-free shifter. A job loads an operand and
//                performs up to WIDTH single-bit shifts, one per clock. The
//                shift is left or right, and each step either fills with zero
//                or rotates. The result is flagged by a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 5,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic             rotate,
    input  logic [CW-1:0]    count,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    remaining
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // WIDTH expressed in the count width. It is only selected when count
    // exceeds WIDTH, which implies that WIDTH fits in CW bits.
    localparam logic [CW-1:0] c_WIDTH_CW = CW'(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_dir;
    logic             r_rot;
    logic [CW-1:0]    r_rem;

    logic [CW-1:0]    w_clamp;
    logic [WIDTH-1:0] w_shifted;
    logic             w_fill;

    // Requested count, saturated to the operand width.
    assign w_clamp = (32'(count) > 32'(WIDTH)) ? c_WIDTH_CW : count;

    // Apply one single-bit step using the direction and mode latched at accept.
    always_comb begin
        w_fill    = 1'b0;
        w_shifted = r_q;
        if (r_dir) begin
            w_fill    = r_rot ? r_q[WIDTH-1] : 1'b0;
            w_shifted = {r_q[WIDTH-2:0], w_fill};
        end else begin
            w_fill    = r_rot ? r_q[0] : 1'b0;
            w_shifted = {w_fill, r_q[WIDTH-1:1]};
        end
    end

    // Control FSM and working register. Inputs are sampled only in IDLE, so a
    // job in flight cannot be disturbed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_q     <= '0;
            r_dir   <= 1'b0;
            r_rot   <= 1'b0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_q     <= A;
                        r_dir   <= dir;
                        r_rot   <= rotate;
                        r_rem   <= w_clamp;
                        r_state <= (w_clamp != '0) ? c_SHIFT : c_DONE;
                    end
                end
                c_SHIFT: begin
                    r_q   <= w_shifted;
                    r_rem <= r_rem - CW'(1);
                    if (r_rem == CW'(1)) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign Q         = r_q;
    assign busy      = (r_state == c_SHIFT);
    assign done      = (r_state == c_DONE);
    assign remaining = r_rem;

endmodule
`default_nettype wire
